// File: rtl/hazard_pkg.sv
// Shared encodings for the ID/EX hazard controller: FSM states, the
// zero-register index and the priority arbiter for the hazard events.
package hazard_pkg;

   localparam int DEF_CNT_W = 16;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_BUBBLE = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_FREEZE = 2'd3
   } state_t;

   // The winning event of a cycle doubles as the next FSM state.
   function automatic state_t win_event(input logic busy, input logic br, input logic lu);
      state_t ev;
      if (busy) begin
         ev = ST_FREEZE;
      end else if (br) begin
         ev = ST_FLUSH;
      end else if (lu) begin
         ev = ST_BUBBLE;
      end else begin
         ev = ST_RUN;
      end
      return ev;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_en,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   // Count enabled cycles; async clear, never wrap past all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= {W{1'b0}};
      end else if (i_en && (r_cnt != {W{1'b1}})) begin
         r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// Load-use / taken-branch / memory-freeze controller driving the PC, IF/ID
// and ID/EX enables and flushes, with saturating debug counters.
module id_ex_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] ID_rs,
   input  logic [REG_W-1:0] ID_rt,
   input  logic             ID_uses_rt,
   input  logic             EX_MemRead,
   input  logic [REG_W-1:0] EX_rt,
   input  logic             MEM_Branch,
   input  logic             MEM_Zero,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             IF_ID_write,
   output logic             IF_ID_flush,
   output logic             ID_EX_flush,
   output logic             EX_MEM_flush,
   output logic             freeze,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] freeze_cnt
);

   logic   w_lu_hz;
   logic   w_br_tk;
   state_t w_win;
   state_t r_state;

   assign w_lu_hz = EX_MemRead && (EX_rt != REG_W'(REG_ZERO)) &&
                    ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
   assign w_br_tk = MEM_Branch && MEM_Zero;
   assign w_win   = win_event(mem_busy, w_br_tk, w_lu_hz);

   // Zero-latency control decode of the winning event.
   always_comb begin
      pc_write     = 1'b1;
      IF_ID_write  = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_flush  = 1'b0;
      EX_MEM_flush = 1'b0;
      freeze       = 1'b0;
      case (w_win)
         ST_FREEZE: begin
            freeze      = 1'b1;
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
         end
         ST_FLUSH: begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
         end
         ST_BUBBLE: begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
         end
         ST_RUN: begin
            pc_write = 1'b1;
         end
         default: begin
            pc_write = 1'b1;
         end
      endcase
   end

   // FSM: the next state is simply the event that won this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_win;
      end
   end

   assign state = r_state;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_win == ST_BUBBLE),
      .o_cnt (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_win == ST_FLUSH),
      .o_cnt (flush_cnt)
   );

   sat_counter #(.W(CNT_W)) u_freeze_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_win == ST_FREEZE),
      .o_cnt (freeze_cnt)
   );

endmodule
